// File: rtl/dm_pkg.sv
// Shared types for the data-memory access arbiter: memory access codes,
// FSM states, requester ids and the alignment rule.
package dm_pkg;

    typedef enum logic [2:0] {
        DM_LB  = 3'b000,
        DM_LH  = 3'b001,
        DM_LW  = 3'b010,
        DM_SW  = 3'b011,
        DM_LBU = 3'b100,
        DM_LHU = 3'b101,
        DM_SB  = 3'b110,
        DM_SH  = 3'b111
    } dm_ctrl_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_e;

    // Word ops need a 4-byte boundary, half ops a 2-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (ctrl)
            DM_LW, DM_SW:         mis = (addr_lo != 2'b00);
            DM_LH, DM_LHU, DM_SH: mis = addr_lo[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_rr_arbiter.sv
// Two-way round-robin pick between CPU and loader; the pointer holds the
// last granted requester and resets to the loader so the CPU wins the first tie.
module dm_rr_arbiter
    import dm_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  logic    req_cpu,
    input  logic    req_ld,
    output logic    gnt_cpu,
    output logic    gnt_ld,
    output req_id_e winner
);

    req_id_e last;

    always_comb begin
        winner  = REQ_CPU;
        gnt_cpu = 1'b0;
        gnt_ld  = 1'b0;
        if (req_cpu && req_ld) begin
            winner = (last == REQ_LD) ? REQ_CPU : REQ_LD;
        end else if (req_ld) begin
            winner = REQ_LD;
        end
        if (en) begin
            gnt_cpu = req_cpu && (winner == REQ_CPU);
            gnt_ld  = req_ld && (winner == REQ_LD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= REQ_LD;
        end else if (gnt_cpu) begin
            last <= REQ_CPU;
        end else if (gnt_ld) begin
            last <= REQ_LD;
        end
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Shares the single-port data memory between the CPU and loader ports.
// Optional saturating grant/wait counters are enabled with DM_ARB_PERF_EN.
//
// state  | meaning
// IDLE   | arbitrate; grant one requester and latch its command
// ACCESS | drive memory from the command register, capture the response
module dm_access_arbiter
   import dm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
`ifdef DM_ARB_PERF_EN
   output logic [CNT_W-1:0]  CpuGrantCnt,
   output logic [CNT_W-1:0]  LdGrantCnt,
   output logic [CNT_W-1:0]  CpuWaitCnt,
   output logic [CNT_W-1:0]  LdWaitCnt,
`endif
   input  logic              CpuReq,
   input  logic [ADDR_W-1:0] CpuAddr,
   input  logic [DATA_W-1:0] CpuDataWr,
   input  logic              CpuWr,
   input  logic [2:0]        CpuCtrl,
   output logic              CpuGnt,
   output logic              CpuRdValid,
   output logic [DATA_W-1:0] CpuRdData,
   output logic              CpuErr,
   input  logic              LdReq,
   input  logic [ADDR_W-1:0] LdAddr,
   input  logic [DATA_W-1:0] LdDataWr,
   input  logic              LdWr,
   input  logic [2:0]        LdCtrl,
   output logic              LdGnt,
   output logic              LdRdValid,
   output logic [DATA_W-1:0] LdRdData,
   output logic              LdErr,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] DataWr,
   output logic              DMWr,
   output logic [2:0]        DMCtrl,
   input  logic [DATA_W-1:0] DataRd
);

   arb_state_e        state;
   arb_state_e        state_nxt;
   logic              gnt_cpu;
   logic              gnt_ld;
   logic              any_gnt;
   req_id_e           winner;

   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_wr;
   logic [2:0]        cmd_ctrl;
   req_id_e           cmd_id;
   logic              cmd_mis;
   logic [DATA_W-1:0] rsp_data;

   dm_rr_arbiter u_arb (
      .clk     (clk),
      .rst     (rst),
      .en      ((state == IDLE) && !rst),
      .req_cpu (CpuReq),
      .req_ld  (LdReq),
      .gnt_cpu (gnt_cpu),
      .gnt_ld  (gnt_ld),
      .winner  (winner)
   );

   assign CpuGnt   = gnt_cpu;
   assign LdGnt    = gnt_ld;
   assign any_gnt  = gnt_cpu || gnt_ld;
   assign cmd_mis  = is_misaligned(cmd_ctrl, cmd_addr[1:0]);
   // Stores and misaligned accesses answer with zero data.
   assign rsp_data = (cmd_wr || cmd_mis) ? '0 : DataRd;

   always_comb begin
      state_nxt = state;
      Address   = '0;
      DataWr    = '0;
      DMWr      = 1'b0;
      DMCtrl    = DM_LW;
      case (state)
         IDLE: begin
            if (any_gnt) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            state_nxt = IDLE;
            Address   = cmd_addr;
            DataWr    = cmd_data;
            DMCtrl    = cmd_ctrl;
            DMWr      = cmd_wr && !cmd_mis && !rst;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cmd_addr   <= '0;
         cmd_data   <= '0;
         cmd_wr     <= 1'b0;
         cmd_ctrl   <= '0;
         cmd_id     <= REQ_CPU;
         CpuRdValid <= 1'b0;
         CpuRdData  <= '0;
         CpuErr     <= 1'b0;
         LdRdValid  <= 1'b0;
         LdRdData   <= '0;
         LdErr      <= 1'b0;
      end else begin
         state      <= state_nxt;
         CpuRdValid <= 1'b0;
         LdRdValid  <= 1'b0;
         if (any_gnt) begin
            cmd_addr <= (winner == REQ_LD) ? LdAddr   : CpuAddr;
            cmd_data <= (winner == REQ_LD) ? LdDataWr : CpuDataWr;
            cmd_wr   <= (winner == REQ_LD) ? LdWr     : CpuWr;
            cmd_ctrl <= (winner == REQ_LD) ? LdCtrl   : CpuCtrl;
            cmd_id   <= winner;
         end
         if (state == ACCESS) begin
            if (cmd_id == REQ_CPU) begin
               CpuRdValid <= 1'b1;
               CpuRdData  <= rsp_data;
               CpuErr     <= cmd_mis;
            end else begin
               LdRdValid  <= 1'b1;
               LdRdData   <= rsp_data;
               LdErr      <= cmd_mis;
            end
         end
      end
   end

`ifdef DM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         CpuGrantCnt <= '0;
         LdGrantCnt  <= '0;
         CpuWaitCnt  <= '0;
         LdWaitCnt   <= '0;
      end else begin
         if (gnt_cpu && (CpuGrantCnt != '1)) CpuGrantCnt <= CpuGrantCnt + 1'b1;
         if (gnt_ld && (LdGrantCnt != '1))   LdGrantCnt  <= LdGrantCnt + 1'b1;
         if (CpuReq && !gnt_cpu && (CpuWaitCnt != '1)) CpuWaitCnt <= CpuWaitCnt + 1'b1;
         if (LdReq && !gnt_ld && (LdWaitCnt != '1))    LdWaitCnt  <= LdWaitCnt + 1'b1;
      end
   end
`endif

`ifndef SYNTHESIS
   // A requester must hold its request until it is granted.
   property p_req_held(logic req, logic gnt);
      @(posedge clk) disable iff (rst) (req && !gnt) |=> req;
   endproperty
   a_cpu_req_held: assert property (p_req_held(CpuReq, CpuGnt));
   a_ld_req_held:  assert property (p_req_held(LdReq, LdGnt));
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter: a transaction-level model predicts
// every output each cycle; literal checks pin the model on the key scenarios.
module tb_dm_access_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 3;
   localparam logic [2:0] C_LB = 3'b000, C_LH = 3'b001, C_LW = 3'b010, C_SW = 3'b011;
   localparam logic [2:0] C_LBU = 3'b100, C_LHU = 3'b101, C_SB = 3'b110, C_SH = 3'b111;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic CpuReq, CpuWr, CpuGnt, CpuRdValid, CpuErr;
   logic [ADDR_W-1:0] CpuAddr;
   logic [DATA_W-1:0] CpuDataWr, CpuRdData;
   logic [2:0] CpuCtrl;
   logic LdReq, LdWr, LdGnt, LdRdValid, LdErr;
   logic [ADDR_W-1:0] LdAddr;
   logic [DATA_W-1:0] LdDataWr, LdRdData;
   logic [2:0] LdCtrl;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] DataWr, DataRd;
   logic DMWr;
   logic [2:0] DMCtrl;

`ifdef DM_ARB_PERF_EN
   logic [CNT_W-1:0] CpuGrantCnt, LdGrantCnt, CpuWaitCnt, LdWaitCnt;
   logic [CNT_W-1:0] m_gc [2];
   logic [CNT_W-1:0] m_wc [2];
`endif

   dm_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
`ifdef DM_ARB_PERF_EN
      .CpuGrantCnt(CpuGrantCnt), .LdGrantCnt(LdGrantCnt),
      .CpuWaitCnt(CpuWaitCnt), .LdWaitCnt(LdWaitCnt),
`endif
      .CpuReq(CpuReq), .CpuAddr(CpuAddr), .CpuDataWr(CpuDataWr), .CpuWr(CpuWr),
      .CpuCtrl(CpuCtrl), .CpuGnt(CpuGnt), .CpuRdValid(CpuRdValid),
      .CpuRdData(CpuRdData), .CpuErr(CpuErr),
      .LdReq(LdReq), .LdAddr(LdAddr), .LdDataWr(LdDataWr), .LdWr(LdWr),
      .LdCtrl(LdCtrl), .LdGnt(LdGnt), .LdRdValid(LdRdValid),
      .LdRdData(LdRdData), .LdErr(LdErr),
      .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
      .DataRd(DataRd)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int dmwr_seen = 0;
   int dual_gnt  = 0;
   int g_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory semantics: little-endian bytes, the memory performs extension.
   function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] c);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*a +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (c)
         C_LB:    return {{24{b[7]}}, b};
         C_LBU:   return {24'h0, b};
         C_LH:    return {{16{h[15]}}, h};
         C_LHU:   return {16'h0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] wr_merge(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] c, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      case (c)
         C_SB: r[8*a +: 8] = d[7:0];
         C_SH: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
         C_SW: r = d;
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic bit mis_f(input logic [2:0] c, input logic [1:0] a);
      if (c == C_LW || c == C_SW) return a != 2'b00;
      if (c == C_LH || c == C_LHU || c == C_SH) return a[0];
      return 1'b0;
   endfunction

   logic [31:0] dev_mem [0:255];
   assign DataRd = rd_ext(dev_mem[Address[9:2]], Address[1:0], DMCtrl);
   always @(posedge clk) begin
      if (DMWr === 1'b1)
         dev_mem[Address[9:2]] <= wr_merge(dev_mem[Address[9:2]], Address[1:0], DMCtrl, DataWr);
   end

   // Model: one access in flight at a time, response one cycle after it.
   logic [31:0] ref_mem [0:255];
   bit          m_busy = 1'b0;
   int          m_last = 1;
   int          p_id = 0;
   logic [31:0] p_addr = '0, p_data = '0;
   bit          p_wr = 1'b0;
   logic [2:0]  p_ctrl = C_LW;
   bit          m_rv [2] = '{1'b0, 1'b0};
   logic [31:0] m_rd [2] = '{32'h0, 32'h0};
   bit          m_err [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      int win;
      bit e_wr;
      bit mis;
      win = -1;
      if (!rst && !m_busy) begin
         if (CpuReq && LdReq) win = (m_last == 1) ? 0 : 1;
         else if (CpuReq)     win = 0;
         else if (LdReq)      win = 1;
      end
      chk("CpuGnt", CpuGnt, 32'(win == 0));
      chk("LdGnt", LdGnt, 32'(win == 1));
      chk("CpuRdValid", CpuRdValid, 32'(m_rv[0]));
      chk("LdRdValid", LdRdValid, 32'(m_rv[1]));
      if (m_rv[0]) begin
         chk("CpuRdData", CpuRdData, m_rd[0]);
         chk("CpuErr", CpuErr, 32'(m_err[0]));
      end
      if (m_rv[1]) begin
         chk("LdRdData", LdRdData, m_rd[1]);
         chk("LdErr", LdErr, 32'(m_err[1]));
      end
      e_wr = m_busy && p_wr && !mis_f(p_ctrl, p_addr[1:0]) && !rst;
      chk("Address", Address, m_busy ? p_addr : 32'h0);
      chk("DataWr", DataWr, m_busy ? p_data : 32'h0);
      chk("DMCtrl", 32'(DMCtrl), m_busy ? 32'(p_ctrl) : 32'(C_LW));
      chk("DMWr", DMWr, 32'(e_wr));
      if (DMWr === 1'b1) dmwr_seen++;
      if (CpuGnt === 1'b1 && LdGnt === 1'b1) dual_gnt++;
      if (CpuGnt === 1'b1) g_q.push_back(0);
      if (LdGnt === 1'b1) g_q.push_back(1);
`ifdef DM_ARB_PERF_EN
      chk("CpuGrantCnt", 32'(CpuGrantCnt), 32'(m_gc[0]));
      chk("LdGrantCnt", 32'(LdGrantCnt), 32'(m_gc[1]));
      chk("CpuWaitCnt", 32'(CpuWaitCnt), 32'(m_wc[0]));
      chk("LdWaitCnt", 32'(LdWaitCnt), 32'(m_wc[1]));
      if (rst) begin
         m_gc = '{'0, '0};
         m_wc = '{'0, '0};
      end else begin
         if (win == 0 && m_gc[0] != '1) m_gc[0]++;
         if (win == 1 && m_gc[1] != '1) m_gc[1]++;
         if (CpuReq && win != 0 && m_wc[0] != '1) m_wc[0]++;
         if (LdReq && win != 1 && m_wc[1] != '1) m_wc[1]++;
      end
`endif
      m_rv = '{1'b0, 1'b0};
      if (rst) begin
         m_busy = 1'b0;
         m_last = 1;
         m_rd   = '{32'h0, 32'h0};
         m_err  = '{1'b0, 1'b0};
      end else if (m_busy) begin
         mis = mis_f(p_ctrl, p_addr[1:0]);
         m_rv[p_id]  = 1'b1;
         m_err[p_id] = mis;
         m_rd[p_id]  = (p_wr || mis) ? 32'h0 : rd_ext(ref_mem[p_addr[9:2]], p_addr[1:0], p_ctrl);
         if (p_wr && !mis)
            ref_mem[p_addr[9:2]] = wr_merge(ref_mem[p_addr[9:2]], p_addr[1:0], p_ctrl, p_data);
         m_busy = 1'b0;
      end else if (win >= 0) begin
         p_id   = win;
         p_addr = (win == 1) ? LdAddr : CpuAddr;
         p_data = (win == 1) ? LdDataWr : CpuDataWr;
         p_wr   = (win == 1) ? LdWr : CpuWr;
         p_ctrl = (win == 1) ? LdCtrl : CpuCtrl;
         m_busy = 1'b1;
         m_last = win;
      end
   end

   task automatic set_req(input int id, input bit req, input logic [31:0] addr,
                          input logic [31:0] data, input bit wr, input logic [2:0] ctrl);
      if (id == 0) begin
         CpuReq = req; CpuAddr = addr; CpuDataWr = data; CpuWr = wr; CpuCtrl = ctrl;
      end else begin
         LdReq = req; LdAddr = addr; LdDataWr = data; LdWr = wr; LdCtrl = ctrl;
      end
   endtask

   task automatic access(input int id, input logic [31:0] addr, input logic [31:0] data,
                         input bit wr, input logic [2:0] ctrl,
                         output logic [31:0] rdata, output bit err, output int lat);
      bit got;
      rdata = 32'hx;
      err   = 1'bx;
      lat   = -1;
      @(posedge clk); #1;
      set_req(id, 1'b1, addr, data, wr, ctrl);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((id == 0 && CpuGnt === 1'b1) || (id == 1 && LdGnt === 1'b1)) got = 1'b1;
      end
      @(posedge clk); #1;
      set_req(id, 1'b0, 32'h0, 32'h0, 1'b0, C_LW);
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL grant_timeout: requester %0d got no grant, required one within 20 cycles", id);
         return;
      end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (id == 0 && CpuRdValid === 1'b1) begin rdata = CpuRdData; err = CpuErr; got = 1'b1; lat = i + 1; end
         if (id == 1 && LdRdValid === 1'b1)  begin rdata = LdRdData;  err = LdErr;  got = 1'b1; lat = i + 1; end
      end
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL resp_timeout: requester %0d got no RdValid, required one within 10 cycles", id);
      end
   endtask

   task automatic contend(input int n);
      int cg, lg;
      cg = 0; lg = 0;
      g_q.delete();
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'h10, 32'h0, 1'b0, C_LW);
      set_req(1, 1'b1, 32'h20, 32'h0, 1'b0, C_LW);
      for (int i = 0; i < 40 && (CpuReq || LdReq); i++) begin
         @(negedge clk);
         if (CpuGnt === 1'b1) cg++;
         if (LdGnt === 1'b1) lg++;
         @(posedge clk); #1;
         if (cg >= n) CpuReq = 1'b0;
         if (lg >= n) LdReq = 1'b0;
      end
      if (CpuReq || LdReq) begin
         n_tests++; n_fail++;
         $display("FAIL contend_timeout: grants cpu=%0d ld=%0d, required %0d each", cg, lg, n);
         CpuReq = 1'b0; LdReq = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish by 100000");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      bit er;
      int lat;
      int rv_seen;
      logic [3:0] order;
      rst = 1'b1;
      set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, C_LW);
      set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, C_LW);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_CpuGnt", CpuGnt, 32'h0);
      chk("reset_LdRdValid", LdRdValid, 32'h0);
      chk("reset_CpuRdData", CpuRdData, 32'h0);
      chk("reset_LdErr", LdErr, 32'h0);
      chk("reset_Address", Address, 32'h0);
      chk("reset_DMCtrl", 32'(DMCtrl), 32'h2);
      @(posedge clk); #1 rst = 1'b0;

      dmwr_seen = 0;
      access(0, 32'h10, 32'hDEADBEEF, 1'b1, C_SW, rd, er, lat);
      chk("sw10_dmwr_count", dmwr_seen, 32'd1);
      chk("sw10_rdata", rd, 32'h0);
      chk("sw10_latency", lat, 32'd2);
      access(0, 32'h10, 32'h0, 1'b0, C_LW, rd, er, lat);
      chk("lw10_rdata", rd, 32'hDEADBEEF);
      chk("lw10_err", 32'(er), 32'h0);
      chk("lw10_latency", lat, 32'd2);

      access(1, 32'h20, 32'h55667788, 1'b1, C_SW, rd, er, lat);
      dmwr_seen = 0;
      access(1, 32'h21, 32'h0000BEEF, 1'b1, C_SH, rd, er, lat);
      chk("sh21_dmwr_count", dmwr_seen, 32'd0);
      chk("sh21_err", 32'(er), 32'h1);
      chk("sh21_rdata", rd, 32'h0);
      access(1, 32'h20, 32'h0, 1'b0, C_LW, rd, er, lat);
      chk("lw20_rdata", rd, 32'h55667788);

      access(0, 32'h13, 32'h000000AA, 1'b1, C_SB, rd, er, lat);
      access(0, 32'h13, 32'h0, 1'b0, C_LBU, rd, er, lat);
      chk("lbu13_rdata", rd, 32'h000000AA);
      access(0, 32'h13, 32'h0, 1'b0, C_LB, rd, er, lat);
      chk("lb13_rdata", rd, 32'hFFFFFFAA);
      access(0, 32'h10, 32'h0, 1'b0, C_LW, rd, er, lat);
      chk("lw10_after_sb", rd, 32'hAAADBEEF);
      access(0, 32'h12, 32'h0, 1'b0, C_LHU, rd, er, lat);
      chk("lhu12_rdata", rd, 32'h0000AAAD);

      access(0, 32'h40, 32'hCAFEF00D, 1'b1, C_SW, rd, er, lat);
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'h40, 32'h11111111, 1'b1, C_SW);
      @(negedge clk);
      chk("rstacc_gnt", CpuGnt, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      set_req(0, 1'b0, 32'h0, 32'h0, 1'b0, C_LW);
      @(negedge clk);
      chk("rstacc_dmwr", DMWr, 32'h0);
      chk("rstacc_addr", Address, 32'h40);
      @(posedge clk); #1 rst = 1'b0;
      rv_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (CpuRdValid === 1'b1) rv_seen++;
      end
      chk("rstacc_no_rdvalid", rv_seen, 32'd0);
      access(0, 32'h40, 32'h0, 1'b0, C_LW, rd, er, lat);
      chk("lw40_old_value", rd, 32'hCAFEF00D);
      chk("lw40_latency", lat, 32'd2);

      pulse_reset();
      dual_gnt = 0;
      contend(2);
      order = '0;
      foreach (g_q[i]) order = {order[2:0], g_q[i][0]};
      chk("contend_grant_count", g_q.size(), 32'd4);
      chk("contend_order_CLCL", 32'(order), 32'b0101);
      chk("contend_dual_gnt", dual_gnt, 32'd0);
`ifdef DM_ARB_PERF_EN
      chk("perf_cpu_grants", 32'(CpuGrantCnt), 32'd2);
      chk("perf_ld_grants", 32'(LdGrantCnt), 32'd2);
      chk("perf_cpu_waits", 32'(CpuWaitCnt), 32'd3);
      chk("perf_ld_waits", 32'(LdWaitCnt), 32'd5);
      contend(2);
      contend(2);
      contend(2);
      chk("perf_cpu_grants_sat", 32'(CpuGrantCnt), 32'd7);
      chk("perf_ld_grants_sat", 32'(LdGrantCnt), 32'd7);
      chk("perf_cpu_waits_sat", 32'(CpuWaitCnt), 32'd7);
      chk("perf_ld_waits_sat", 32'(LdWaitCnt), 32'd7);
`else
      contend(3);
      order = '0;
      foreach (g_q[i]) if (i < 4) order = {order[2:0], g_q[i][0]};
      chk("contend3_grant_count", g_q.size(), 32'd6);
      chk("contend3_order", 32'(order), 32'b0101);
      chk("contend3_dual_gnt", dual_gnt, 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Two-requester controller that shares the single-port data memory between the CPU load/store path and a loader/debug port.
- Sequences each access as a registered command cycle, then a registered response.
- Round-robin arbitration; checks alignment and blocks misaligned writes.
- Sits between the requesters and the data memory; drives Address/DataWr/DMWr/DMCtrl and samples DataRd.

Parameters:
- DATA_W, 32, data width; must match the memory word.
- ADDR_W, 32, byte-address width.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- CpuReq  in  1  CPU request; held with its payload until CpuGnt.
- CpuAddr  in  ADDR_W  CPU byte address.
- CpuDataWr  in  DATA_W  CPU store data.
- CpuWr  in  1  1 = store.
- CpuCtrl  in  3  access type, using the DMCtrl encoding.
- CpuGnt  out  1  payload accepted this cycle.
- CpuRdValid  out  1  one-cycle response strobe (loads and stores).
- CpuRdData  out  DATA_W  load result.
- CpuErr  out  1  misaligned, valid with CpuRdValid.
- LdReq, LdAddr, LdDataWr, LdWr, LdCtrl, LdGnt, LdRdValid, LdRdData, LdErr: same widths and meaning for the loader port.
- Address  out  ADDR_W  to memory.
- DataWr  out  DATA_W  to memory.
- DMWr  out  1  to memory.
- DMCtrl  out  3  to memory.
- DataRd  in  DATA_W  from memory.

Behaviour:
- DMCtrl encoding, defined in the package: LB 000, LH 001, LW 010, SW 011, LBU 100, LHU 101, SB 110, SH 111.
- FSM states: IDLE, ACCESS.
  - IDLE: if any Req is high, grant exactly one requester (Gnt=1, combinational), latch its Addr/DataWr/Wr/Ctrl into the command register, record the requester, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive the memory from the command register for one cycle, capture DataRd into the winner's RdData register, then go to IDLE.
- Latency and throughput:
  - Request granted in cycle N; memory driven in N+1; RdValid=1 with RdData valid in N+2.
  - Gnt only asserts in IDLE, so the next grant may coincide with the previous RdValid. Throughput is one access per 2 cycles.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the requester not granted last wins.
  - The last-granted pointer resets to Ld, so the CPU wins the first tie.
- Alignment:
  - Misaligned = word op (LW/SW) with Addr[1:0]≠00, or half op (LH/LHU/SH) with Addr[0]=1. Byte ops are never misaligned.
  - A misaligned access still takes its ACCESS cycle, but DMWr=0 and the response returns RdData=0, Err=1.
- Memory outputs:
  - Outside ACCESS: Address=0, DataWr=0, DMWr=0, DMCtrl=LW.
  - In ACCESS: DMWr = Wr & ~misaligned & ~rst.
- Loads return DataRd unmodified; the memory performs extension. Stores return RdValid=1, RdData=0, Err=0 unless misaligned.
- Reset values: state=IDLE; all Gnt/RdValid/Err=0; RdData=0; command register=0; pointer=Ld.
- Reset in ACCESS: the write is suppressed that cycle, no response is issued, and the FSM returns to IDLE.
- A Req dropped before Gnt is a protocol violation; behaviour is undefined, and it is assertion-checked in simulation only.

Optional Feature:
- Macro: DM_ARB_PERF_EN.
- Defined:
  - Adds output ports CpuGrantCnt, LdGrantCnt, CpuWaitCnt, LdWaitCnt, each CNT_W wide.
  - Grant counters increment on each Gnt.
  - Wait counters increment each cycle Req=1 and Gnt=0.
  - All counters saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dm_pkg holds:
  - the dm_ctrl_e enum (the 8 codes above);
  - the arb_state_e enum (IDLE, ACCESS);
  - the requester id enum (REQ_CPU, REQ_LD);
  - the helper function is_misaligned(ctrl, addr[1:0]).
- One sub-module: dm_rr_arbiter, the 2-way round-robin pick with pointer register. The counters stay inline.

Test Plan:
- CPU-only SW Addr=0x10, Data=0xDEADBEEF, then LW 0x10 -> DMWr=1 for exactly one cycle; CpuRdData=0xDEADBEEF at grant+2; Err=0.
- CpuReq and LdReq both held for 6 cycles -> grants alternate CPU, Ld, CPU, Ld, …; the first tie goes to CPU; no cycle has two Gnts.
- Ld SH Addr=0x21 -> DMWr never asserts; LdRdValid=1 with LdErr=1, LdRdData=0. A following LW 0x20 returns the prior contents.
- CPU SB Addr=0x13, Data=0xAA, then LBU 0x13 -> 0x000000AA; LB 0x13 -> 0xFFFFFFAA.
- rst asserted in the ACCESS cycle of SW 0x40 -> no write occurs, no RdValid, FSM back in IDLE; a later LW 0x40 returns the old value.
- With DM_ARB_PERF_EN, 4 contended accesses -> CpuGrantCnt=2, LdGrantCnt=2, wait counters match cycle-counted Req&~Gnt; counters saturate when preset near max.
